// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin share of one memory port between the core sequencer (C) and debug/loader (D).
// Latency: grant 1 cycle after req; done 1 cycle after mem_data_ready (or after TIMEOUT stalled BUSY cycles).
// Backpressure: one transaction in flight; req is sampled only in IDLE, the memory side stalls via mem_data_ready.
// Ports: clk/rst_n (sync, active-low); c_*/d_* requester buses with done/err pulses and held rdata;
//        mem_* latched command to memory plus mem_data_ready/mem_rdata back; owner = 00 idle, 01 C, 10 D.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        c_req,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   input  logic        c_write,
   input  logic [3:0]  c_size,
   output logic        c_done,
   output logic        c_err,
   output logic [31:0] c_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_write,
   input  logic [3:0]  d_size,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_size,
   output logic        mem_addr_ready,
   input  logic        mem_data_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  owner
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_C = 2'd1, BUSY_D = 2'd2} state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        last_d_q, last_d_d;     // 1: D had the most recent grant, so C wins a tie
   logic [7:0]  timer_q, timer_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        write_q, write_d;
   logic [3:0]  size_q, size_d;
   logic        c_done_q, c_done_d, c_err_q, c_err_d;
   logic        d_done_q, d_done_d, d_err_q, d_err_d;
   logic [31:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
   logic        busy, finish, timed_out;
   logic [31:0] result;

   always_comb begin
      state_d   = state_q;
      last_d_d  = last_d_q;
      timer_d   = timer_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      size_d    = size_q;
      c_done_d  = 1'b0;
      c_err_d   = 1'b0;
      d_done_d  = 1'b0;
      d_err_d   = 1'b0;
      c_rdata_d = c_rdata_q;
      d_rdata_d = d_rdata_q;
      // mem_data_ready on the timeout edge wins: the access completed normally.
      finish    = mem_data_ready || (timer_q == TMO_LAST);
      timed_out = !mem_data_ready;
      result    = timed_out ? 32'h0 : mem_rdata;

      unique case (state_q)
         IDLE: begin
            if (c_req && (!d_req || last_d_q)) begin
               state_d  = BUSY_C;
               last_d_d = 1'b0;
               timer_d  = 8'd0;
               addr_d   = c_addr;
               wdata_d  = c_wdata;
               write_d  = c_write;
               size_d   = c_size;
            end else if (d_req) begin
               state_d  = BUSY_D;
               last_d_d = 1'b1;
               timer_d  = 8'd0;
               addr_d   = d_addr;
               wdata_d  = d_wdata;
               write_d  = d_write;
               size_d   = d_size;
            end
         end
         BUSY_C, BUSY_D: begin
            if (finish) begin
               state_d = IDLE;
               timer_d = 8'd0;
               addr_d  = 32'h0;
               wdata_d = 32'h0;
               write_d = 1'b0;
               size_d  = 4'h0;
               if (state_q == BUSY_C) begin
                  c_done_d = 1'b1;
                  c_err_d  = timed_out;
                  // Stores keep the previous load data unless the store timed out.
                  if (timed_out || !write_q) c_rdata_d = result;
               end else begin
                  d_done_d = 1'b1;
                  d_err_d  = timed_out;
                  if (timed_out || !write_q) d_rdata_d = result;
               end
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_d_q  <= 1'b1;
         timer_q   <= 8'd0;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         write_q   <= 1'b0;
         size_q    <= 4'h0;
         c_done_q  <= 1'b0;
         c_err_q   <= 1'b0;
         d_done_q  <= 1'b0;
         d_err_q   <= 1'b0;
         c_rdata_q <= 32'h0;
         d_rdata_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         timer_q   <= timer_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
         size_q    <= size_d;
         c_done_q  <= c_done_d;
         c_err_q   <= c_err_d;
         d_done_q  <= d_done_d;
         d_err_q   <= d_err_d;
         c_rdata_q <= c_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign busy           = (state_q != IDLE);
   assign mem_addr_ready = busy;
   assign mem_read       = busy && !write_q;
   assign mem_write      = busy && write_q;
   assign mem_addr       = addr_q;
   assign mem_wdata      = wdata_q;
   assign mem_size       = size_q;
   assign owner          = {state_q == BUSY_D, state_q == BUSY_C};
   assign c_done         = c_done_q;
   assign c_err          = c_err_q;
   assign c_rdata        = c_rdata_q;
   assign d_done         = d_done_q;
   assign d_err          = d_err_q;
   assign d_rdata        = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: scoreboard bench for mem_port_arbiter; directed transactions push expected completions,
// a negedge monitor pops and compares them whenever a done pulse appears.
// Timing: inputs driven #1 after posedge or at negedge; outputs sampled on negedge.
module tb_mem_port_arbiter;
   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c_req, c_write, d_req, d_write;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic [3:0]  c_size, d_size;
   logic        c_done, c_err, d_done, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, mem_addr_ready, mem_data_ready;
   logic [3:0]  mem_size;
   logic [1:0]  owner;

   typedef struct {
      logic        port_d;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   mem_port_arbiter #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata), .c_write(c_write), .c_size(c_size),
      .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write), .d_size(d_size),
      .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_addr_ready(mem_addr_ready), .mem_data_ready(mem_data_ready),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic pd, input logic er, input logic [31:0] rd);
      exp_t e;
      e.port_d = pd;
      e.err    = er;
      e.rdata  = rd;
      return e;
   endfunction

   // Called #1 after the grant edge; memory answers in the nbusy-th BUSY cycle.
   // Returns at the negedge of the IDLE cycle that follows completion.
   task automatic serve(input logic [1:0] own, input logic [31:0] addr, input logic wr,
                        input int nbusy, input logic [31:0] rd);
      for (int i = 1; i <= nbusy; i++) begin
         mem_data_ready = (i == nbusy);
         mem_rdata      = (i == nbusy) ? rd : 32'h0BAD_0BAD;
         @(negedge clk);
         chk("owner", {30'h0, owner}, {30'h0, own});
         chk("addr_ready_busy", {31'h0, mem_addr_ready}, 32'h1);
         chk("mem_addr", mem_addr, addr);
         chk("mem_write", {31'h0, mem_write}, {31'h0, wr});
         chk("mem_read", {31'h0, mem_read}, {31'h0, !wr});
         @(posedge clk); #1;
      end
      mem_data_ready = 1'b0;
      @(negedge clk);
      chk("addr_ready_drop", {31'h0, mem_addr_ready}, 32'h0);
      chk("owner_idle", {30'h0, owner}, 32'h0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (c_done || d_done) begin
         chk("done_overlap", {31'h0, c_done & d_done}, 32'h0);
         chk("other_err", {31'h0, d_done ? c_err : d_err}, 32'h0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: c_done=%b d_done=%b with no expected entry at %0t",
                     c_done, d_done, $time);
         end else begin
            mon_e = sb.pop_front();
            chk("done_port", {31'h0, d_done}, {31'h0, mon_e.port_d});
            chk("done_err", {31'h0, d_done ? d_err : c_err}, {31'h0, mon_e.err});
            chk("done_rdata", d_done ? d_rdata : c_rdata, mon_e.rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      c_req = 1'b1; c_addr = 32'h100; c_wdata = 32'h0; c_write = 1'b0; c_size = 4'h0;
      d_req = 1'b1; d_addr = 32'h0;   d_wdata = 32'h0; d_write = 1'b0; d_size = 4'h0;
      mem_data_ready = 1'b0; mem_rdata = 32'h0;

      // Reset held 2 cycles with both requests high
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_owner", {30'h0, owner}, 32'h0);
      chk("rst_addr_ready", {31'h0, mem_addr_ready}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_rw", {30'h0, mem_read, mem_write}, 32'h0);
      chk("rst_done", {28'h0, c_done, c_err, d_done, d_err}, 32'h0);
      chk("rst_c_rdata", c_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single C load after reset: C wins the tie, 3 BUSY cycles
      sb.push_back(mk(1'b0, 1'b0, 32'hDEAD_BEEF));
      @(posedge clk); #1;
      c_req = 1'b0; d_req = 1'b0;
      serve(2'b01, 32'h100, 1'b0, 3, 32'hDEAD_BEEF);

      // D-only load, so the next tie goes to C
      d_req = 1'b1; d_addr = 32'h200; d_write = 1'b0;
      sb.push_back(mk(1'b1, 1'b0, 32'hCAFE_F00D));
      @(posedge clk); #1;
      d_req = 1'b0;
      serve(2'b10, 32'h200, 1'b0, 1, 32'hCAFE_F00D);

      // Contention: C stores, D loads, both held -> 01,10,01,10
      c_req = 1'b1; c_write = 1'b1; c_addr = 32'h300; c_wdata = 32'h1234;
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h400;
      for (int k = 0; k < 4; k++) begin
         if (k[0]) sb.push_back(mk(1'b1, 1'b0, 32'h1111_0000 + k));
         else      sb.push_back(mk(1'b0, 1'b0, 32'hDEAD_BEEF));
         @(posedge clk); #1;
         if (k == 3) begin c_req = 1'b0; d_req = 1'b0; end
         if (k[0]) serve(2'b10, 32'h400, 1'b0, 1, 32'h1111_0000 + k);
         else      serve(2'b01, 32'h300, 1'b1, 1, 32'h0BAD_0BAD);
      end

      // Timeout on a D store; C request arriving mid-flight is granted afterwards
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h500; d_wdata = 32'h55;
      sb.push_back(mk(1'b1, 1'b1, 32'h0));
      @(posedge clk); #1;
      d_req = 1'b0;
      c_req = 1'b1; c_write = 1'b0; c_addr = 32'h600;
      for (int i = 1; i <= TMO; i++) begin
         @(negedge clk);
         chk("tmo_busy", {31'h0, mem_addr_ready}, 32'h1);
         chk("tmo_no_done", {31'h0, d_done}, 32'h0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("tmo_done", {30'h0, d_done, d_err}, 32'h3);
      chk("tmo_rdata", d_rdata, 32'h0);
      chk("tmo_released", {31'h0, mem_addr_ready}, 32'h0);
      sb.push_back(mk(1'b0, 1'b0, 32'h1234_5678));
      @(posedge clk); #1;
      c_req = 1'b0;
      serve(2'b01, 32'h600, 1'b0, 2, 32'h1234_5678);

      // mem_data_ready on the timeout edge: normal completion
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h700;
      sb.push_back(mk(1'b1, 1'b0, 32'hA5A5_5A5A));
      @(posedge clk); #1;
      d_req = 1'b0;
      serve(2'b10, 32'h700, 1'b0, TMO, 32'hA5A5_5A5A);

      // Reset during BUSY_C: transaction abandoned, no done
      c_req = 1'b1; c_addr = 32'h800; c_write = 1'b0;
      @(posedge clk); #1;
      c_req = 1'b0;
      @(negedge clk);
      chk("mid_busy", {31'h0, mem_addr_ready}, 32'h1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_addr_ready", {31'h0, mem_addr_ready}, 32'h0);
      chk("mid_mem_addr", mem_addr, 32'h0);
      chk("mid_no_done", {31'h0, c_done}, 32'h0);
      chk("mid_c_rdata", c_rdata, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("mid_idle_owner", {30'h0, owner}, 32'h0);
      chk("mid_idle_ready", {31'h0, mem_addr_ready}, 32'h0);

      repeat (2) @(negedge clk);
      chk("sb_empty", sb.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
